// File: rtl/lsm303_accel_poller_if.sv
// Command/response bus between the LSM303 poller and the I2C interface FSM.
// The poller is the master (issues commands), the I2C engine is the slave.
interface lsm303_accel_poller_if;
   logic [6:0]  SlaveAddress;
   logic [6:0]  SubAddress;
   logic        ReadWrite;
   logic [7:0]  WriteData;
   logic [7:0]  BytesToRead;
   logic        I2CStart;
   logic        I2CDone;
   logic        I2CAckError;
   logic [31:0] ReadData;

   modport master (
      output SlaveAddress, SubAddress, ReadWrite, WriteData, BytesToRead, I2CStart,
      input  I2CDone, I2CAckError, ReadData
   );

   modport slave (
      input  SlaveAddress, SubAddress, ReadWrite, WriteData, BytesToRead, I2CStart,
      output I2CDone, I2CAckError, ReadData
   );
endinterface

// File: rtl/lsm303_accel_poller.sv
// Autonomous LSM303 accelerometer sequencer: one configuration write, then
// periodic X/Y and Z burst reads reassembled into signed 16-bit samples.
module lsm303_accel_poller #(
   parameter logic [6:0]  SLAVE_ADDR     = 7'h19,
   parameter logic [6:0]  CTRL_REG       = 7'h20,
   parameter logic [7:0]  CTRL_VALUE     = 8'h57,
   parameter logic [6:0]  OUT_REG        = 7'h28,
   parameter logic [23:0] POLL_CYCLES    = 24'd100000,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd50000
) (
   input  logic                         FSM_Clk,
   input  logic                         Reset,
   input  logic                         Enable,
   lsm303_accel_poller_if.master        bus,
   output logic [15:0]                  AccelX,
   output logic [15:0]                  AccelY,
   output logic [15:0]                  AccelZ,
   output logic                         SampleValid,
   output logic [15:0]                  SampleCount,
   output logic [7:0]                   ErrorCount,
   output logic                         Configured
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_INIT_REQ, ST_INIT_WAIT, ST_PERIOD,
      ST_XY_REQ, ST_XY_WAIT, ST_Z_REQ, ST_Z_WAIT, ST_PUBLISH
   } state_t;

   state_t      state_q;
   logic [23:0] period_cnt_q;
   logic [23:0] wait_cnt_q;
   logic [6:0]  slave_addr_q;
   logic [6:0]  sub_addr_q;
   logic        read_write_q;
   logic [7:0]  write_data_q;
   logic [7:0]  bytes_to_read_q;
   logic        start_q;
   logic [15:0] x_tmp_q;
   logic [15:0] y_tmp_q;
   logic [15:0] accel_x_q;
   logic [15:0] accel_y_q;
   logic [15:0] accel_z_q;
   logic        valid_q;
   logic [15:0] sample_cnt_q;
   logic [7:0]  err_cnt_q;
   logic        configured_q;

   logic in_wait;
   logic wait_ok;
   logic wait_fail;

   // Done beats the timeout when both land in the same cycle.
   always_comb begin
      in_wait   = (state_q == ST_INIT_WAIT) || (state_q == ST_XY_WAIT) || (state_q == ST_Z_WAIT);
      wait_ok   = in_wait && bus.I2CDone && !bus.I2CAckError;
      wait_fail = in_wait && ((bus.I2CDone && bus.I2CAckError) ||
                              (!bus.I2CDone && (wait_cnt_q == TIMEOUT_CYCLES)));
   end

   always_ff @(posedge FSM_Clk or posedge Reset) begin
      if (Reset) begin
         state_q         <= ST_IDLE;
         period_cnt_q    <= '0;
         wait_cnt_q      <= '0;
         slave_addr_q    <= '0;
         sub_addr_q      <= '0;
         read_write_q    <= 1'b0;
         write_data_q    <= '0;
         bytes_to_read_q <= '0;
         start_q         <= 1'b0;
         x_tmp_q         <= '0;
         y_tmp_q         <= '0;
         accel_x_q       <= '0;
         accel_y_q       <= '0;
         accel_z_q       <= '0;
         valid_q         <= 1'b0;
         sample_cnt_q    <= '0;
         err_cnt_q       <= '0;
         configured_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         valid_q <= 1'b0;

         if (wait_fail && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (Enable) begin
                  if (configured_q) begin
                     state_q      <= ST_PERIOD;
                     period_cnt_q <= POLL_CYCLES - 24'd1;
                  end else begin
                     state_q         <= ST_INIT_REQ;
                     slave_addr_q    <= SLAVE_ADDR;
                     sub_addr_q      <= CTRL_REG;
                     read_write_q    <= 1'b0;
                     write_data_q    <= CTRL_VALUE;
                     bytes_to_read_q <= 8'd0;
                     start_q         <= 1'b1;
                  end
               end
            end

            ST_PERIOD: begin
               if (period_cnt_q != 24'd0) begin
                  period_cnt_q <= period_cnt_q - 24'd1;
               end else if (!Enable) begin
                  state_q <= ST_IDLE;
               end else if (!configured_q) begin
                  state_q         <= ST_INIT_REQ;
                  slave_addr_q    <= SLAVE_ADDR;
                  sub_addr_q      <= CTRL_REG;
                  read_write_q    <= 1'b0;
                  write_data_q    <= CTRL_VALUE;
                  bytes_to_read_q <= 8'd0;
                  start_q         <= 1'b1;
               end else begin
                  state_q         <= ST_XY_REQ;
                  slave_addr_q    <= SLAVE_ADDR;
                  sub_addr_q      <= OUT_REG;
                  read_write_q    <= 1'b1;
                  write_data_q    <= 8'd0;
                  bytes_to_read_q <= 8'd4;
                  start_q         <= 1'b1;
               end
            end

            ST_INIT_REQ: begin
               wait_cnt_q <= '0;
               state_q    <= ST_INIT_WAIT;
            end

            ST_XY_REQ: begin
               wait_cnt_q <= '0;
               state_q    <= ST_XY_WAIT;
            end

            ST_Z_REQ: begin
               wait_cnt_q <= '0;
               state_q    <= ST_Z_WAIT;
            end

            ST_INIT_WAIT: begin
               if (wait_ok || wait_fail) begin
                  configured_q <= wait_ok;
                  state_q      <= ST_PERIOD;
                  period_cnt_q <= POLL_CYCLES - 24'd1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 24'd1;
               end
            end

            ST_XY_WAIT: begin
               if (wait_ok) begin
                  x_tmp_q         <= bus.ReadData[15:0];
                  y_tmp_q         <= bus.ReadData[31:16];
                  state_q         <= ST_Z_REQ;
                  sub_addr_q      <= OUT_REG + 7'd4;
                  read_write_q    <= 1'b1;
                  write_data_q    <= 8'd0;
                  bytes_to_read_q <= 8'd2;
                  start_q         <= 1'b1;
               end else if (wait_fail) begin
                  state_q      <= ST_PERIOD;
                  period_cnt_q <= POLL_CYCLES - 24'd1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 24'd1;
               end
            end

            // Z goes straight to the output so all three axes update on the
            // edge that enters PUBLISH, together with SampleValid.
            ST_Z_WAIT: begin
               if (wait_ok) begin
                  accel_x_q    <= x_tmp_q;
                  accel_y_q    <= y_tmp_q;
                  accel_z_q    <= bus.ReadData[15:0];
                  valid_q      <= 1'b1;
                  sample_cnt_q <= sample_cnt_q + 16'd1;
                  state_q      <= ST_PUBLISH;
               end else if (wait_fail) begin
                  state_q      <= ST_PERIOD;
                  period_cnt_q <= POLL_CYCLES - 24'd1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 24'd1;
               end
            end

            ST_PUBLISH: begin
               state_q      <= ST_PERIOD;
               period_cnt_q <= POLL_CYCLES - 24'd1;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.SlaveAddress = slave_addr_q;
   assign bus.SubAddress   = sub_addr_q;
   assign bus.ReadWrite    = read_write_q;
   assign bus.WriteData    = write_data_q;
   assign bus.BytesToRead  = bytes_to_read_q;
   assign bus.I2CStart     = start_q;
   assign AccelX           = accel_x_q;
   assign AccelY           = accel_y_q;
   assign AccelZ           = accel_z_q;
   assign SampleValid      = valid_q;
   assign SampleCount      = sample_cnt_q;
   assign ErrorCount       = err_cnt_q;
   assign Configured       = configured_q;

endmodule
